// File: rtl/calc_pkg.sv
// Shared encodings for the calculator datapath: operation codes and the
// accumulator sequencer states.
package calc_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the building block of the ripple-carry slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_nbits.sv
// N-bit combinational ripple-carry adder built from a chain of full adders.
module rca_nbits #(
   parameter int N = 4
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] S,
   output logic         Cout
);

   logic [N:0] c;

   assign c[0] = Cin;
   assign Cout = c[N];

   for (genvar i = 0; i < N; i++) begin : g_fa
      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (c[i]),
         .s    (S[i]),
         .cout (c[i+1])
      );
   end

endmodule

// File: rtl/rca_accumulator.sv
// Multi-cycle accumulator: adds/subtracts an operand CHUNK bits per clock
// through one shared ripple-carry slice, then commits value and flags.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an op; in_ready high
// BUSY  | one slice per cycle into the shadow sum; acc/flags frozen
// DONE  | result committed this cycle; out_valid pulse, in_ready low
module rca_accumulator #(
   parameter int WIDTH    = 16,
   parameter int CHUNK    = 4,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid
);

   import calc_pkg::*;

   localparam int NCH  = WIDTH / CHUNK;
   localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NCH - 1);
   localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN  = ~SAT_MAX;

   state_e             state_q, state_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   shadow_q, shadow_d;
   logic               cin_q, cin_d;
   logic               carry_q, carry_d;
   logic               overflow_q, overflow_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;

   int                 base;
   logic [CHUNK-1:0]   a_sl, b_sl, s_sl;
   logic               c_sl;
   logic [WIDTH-1:0]   sum_full;
   logic               ovf_now;

   // Select the current slice of acc and latched operand; merge the slice
   // sum into the shadow so the last BUSY cycle sees the complete result.
   always_comb begin
      base     = int'(idx_q) * CHUNK;
      a_sl     = acc_q[base +: CHUNK];
      b_sl     = opb_q[base +: CHUNK];
      sum_full = shadow_q;
      sum_full[base +: CHUNK] = s_sl;
      ovf_now  = (acc_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                 (sum_full[WIDTH-1] != acc_q[WIDTH-1]);
   end

   rca_nbits #(.N(CHUNK)) u_slice (
      .A    (a_sl),
      .B    (b_sl),
      .Cin  (cin_q),
      .S    (s_sl),
      .Cout (c_sl)
   );

   // Sequencer next-state and commit logic; all outputs come from flops.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      shadow_d    = shadow_q;
      cin_d       = cin_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      out_valid_d = 1'b0;
      in_ready_d  = in_ready_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               in_ready_d = 1'b0;
               case (op)
                  OP_ADD, OP_SUB: begin
                     // Subtraction is A + ~B + 1: invert once at accept time.
                     opb_d    = (op == OP_SUB) ? ~operand : operand;
                     cin_d    = (op == OP_SUB);
                     idx_d    = '0;
                     shadow_d = '0;
                     state_d  = BUSY;
                  end
                  OP_LOAD: begin
                     acc_d       = operand;
                     carry_d     = 1'b0;
                     overflow_d  = 1'b0;
                     out_valid_d = 1'b1;
                     state_d     = DONE;
                  end
                  default: begin
                     acc_d       = '0;
                     carry_d     = 1'b0;
                     overflow_d  = 1'b0;
                     out_valid_d = 1'b1;
                     state_d     = DONE;
                  end
               endcase
            end
         end
         BUSY: begin
            shadow_d = sum_full;
            cin_d    = c_sl;
            idx_d    = idx_q + IDXW'(1);
            if (idx_q == IDX_LAST) begin
               carry_d     = c_sl;
               overflow_d  = ovf_now;
               out_valid_d = 1'b1;
               state_d     = DONE;
               if ((SATURATE != 0) && ovf_now)
                  acc_d = acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
               else
                  acc_d = sum_full;
            end
         end
         DONE: begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
         end
         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         opb_q       <= '0;
         shadow_q    <= '0;
         cin_q       <= 1'b0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         shadow_q    <= shadow_d;
         cin_q       <= cin_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign acc       = acc_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign zero      = (acc_q == '0);
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;

endmodule

// File: doc/rca_accumulator.md
Name: rca_accumulator

Overview:
- Parametrised, multi-cycle ripple-carry accumulator for the calculator datapath.
- Accepts an operation and operand through a valid/ready handshake and adds or subtracts the operand into a WIDTH-bit accumulator.
- Processes CHUNK bits per cycle through a small ripple-carry slice, then commits the result and carry/overflow/zero flags to registers and pulses out_valid.
- Sits between the operand-entry logic and the display/register stage; supersedes the fixed 4-bit adder-plus-register pair.

Parameters:
- WIDTH, 16, accumulator/operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; NCH = WIDTH/CHUNK cycles per ADD/SUB.
- SATURATE, 0, 1 = clamp to signed max/min on signed overflow; 0 = wrap.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  op/operand are valid this cycle.
- in_ready  output  1  block can accept an op this cycle.
- op  input  2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- operand  input  WIDTH  operand B.
- acc  output  WIDTH  registered accumulator value.
- carry  output  1  carry out of MSB (SUB: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow of last op.
- zero  output  1  acc == 0 (combinational from acc register).
- out_valid  output  1  one-cycle pulse when a result is committed.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: acc=0, carry=0, overflow=0, out_valid=0, in_ready=1, FSM=IDLE, chunk index=0.
- Accept: transfer occurs when in_valid && in_ready on a rising edge. in_ready is 1 only in IDLE. in_valid while busy is ignored and not queued.
- FSM states:
  - IDLE: on ADD/SUB accept, latch operand (SUB: latch ~operand, carry-in=1; ADD: carry-in=0) and go to BUSY with idx=0. On LOAD/CLEAR accept, go to DONE.
  - BUSY: each cycle, add slice idx of acc and of the latched operand with the running carry, storing the sum into a shadow register. idx increments; the transition on idx==NCH-1 goes to DONE. acc and flags do not change during BUSY.
  - DONE: commit and assert out_valid for exactly this cycle; in_ready=0; return to IDLE next edge.
- Latency:
  - ADD/SUB accepted at edge k: out_valid high in the cycle after edge k+NCH; in_ready high again the cycle after that.
  - LOAD/CLEAR accepted at edge k: out_valid in the cycle after edge k.
- Commit values:
  - ADD/SUB: acc=sum, carry=final slice carry-out, overflow=(A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the operand after inversion for SUB.
  - If SATURATE=1 and overflow: acc=0111..1 when A[msb]=0, else 1000..0; overflow flag still 1; carry reports the unclamped value.
  - LOAD: acc=operand, carry=0, overflow=0.
  - CLEAR: acc=0, carry=0, overflow=0; operand is ignored.
- Wrap: with SATURATE=0, results are modulo 2^WIDTH.
- Reset mid-operation: rst_n low at any time immediately forces all reset values; an in-flight op is dropped and produces no out_valid.
- WIDTH==CHUNK is legal (NCH=1, single BUSY cycle).

Decomposition:
- Shared package calc_pkg: op encoding constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR) and FSM state encoding (IDLE, BUSY, DONE).
- Sub-module rca_nbits: parameter N, ports A[N], B[N], Cin -> S[N], Cout. Purely combinational, built as a generate chain of the existing full_adder. Instantiated once with N=CHUNK.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- Reset: release rst_n -> acc=0x0000, zero=1, carry=0, overflow=0, in_ready=1, out_valid=0.
- LOAD 0xFFFF, then ADD 0x0001 -> acc=0x0000, carry=1, zero=1, overflow=0; out_valid exactly 4 cycles after the ADD accept edge; in_ready=0 throughout.
- LOAD 0x7FFF, ADD 0x0001 -> SATURATE=0: acc=0x8000, overflow=1, carry=0. SATURATE=1: acc=0x7FFF, overflow=1.
- LOAD 0x0005, SUB 0x0007 -> acc=0xFFFE, carry=0, overflow=0. Then SUB 0xFFFE -> acc=0x0000, carry=1, zero=1.
- Hold in_valid=1 with ADD 0x0001 continuously from acc=0 -> accepted only when in_ready=1; acc steps 1,2,3 with one out_valid per op; no op is lost or double-counted.
- ADD accepted, rst_n pulsed low during the 2nd BUSY cycle -> acc=0 immediately; no out_valid; in_ready=1 after release. Repeat with WIDTH=CHUNK=8: out_valid 1 cycle after accept.
